// File: rtl/alu_seq_pkg.sv
// Shared types and ALUop encodings (mirrors ALUop.vh) for the sequential ALU.
package alu_seq_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SH_W   = 5;

    localparam logic [OP_W-1:0] ALU_ADDU = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUBU = 4'd1;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'd2;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'd3;
    localparam logic [OP_W-1:0] ALU_AND  = 4'd4;
    localparam logic [OP_W-1:0] ALU_OR   = 4'd5;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'd6;
    localparam logic [OP_W-1:0] ALU_NOR  = 4'd7;
    localparam logic [OP_W-1:0] ALU_LUI  = 4'd8;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'd9;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'd10;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'd11;
    localparam logic [OP_W-1:0] ALU_XXX  = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle evaluator: logic/arithmetic ops, illegal-code flag, shift detection.
module alu_seq_comb
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned OPW   = OP_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] result_c,
    output logic             illegal_c,
    output logic             is_shift_c
);

    // Shift ops report B so a zero-amount shift completes in one cycle.
    always_comb begin
        result_c   = '0;
        illegal_c  = 1'b0;
        is_shift_c = 1'b0;
        case (op)
            ALU_ADDU: result_c = a + b;
            ALU_SUBU: result_c = a - b;
            ALU_SLT:  result_c = WIDTH'($signed(a) < $signed(b));
            ALU_SLTU: result_c = WIDTH'(a < b);
            ALU_AND:  result_c = a & b;
            ALU_OR:   result_c = a | b;
            ALU_XOR:  result_c = a ^ b;
            ALU_NOR:  result_c = ~(a | b);
            ALU_LUI:  result_c = b << (WIDTH / 2);
            ALU_SLL, ALU_SRL, ALU_SRA: begin
                is_shift_c = 1'b1;
                result_c   = b;
            end
            default:  illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: one-cycle logic/arith ops, iterative one-bit-per-cycle shifts,
// result held until downstream accepts it.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_W,
    parameter int unsigned OPW   = OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OPW-1:0]   ALUop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal
);

    state_t           state, state_n;
    logic [WIDTH-1:0] work, work_n, result_n;
    logic [SH_W-1:0]  cnt, cnt_n;
    logic [OPW-1:0]   op, op_n;
    logic             illegal_n;

    logic [WIDTH-1:0] comb_result_c, shifted_c;
    logic             comb_illegal_c, comb_shift_c;

    alu_seq_comb #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_comb (
        .a          (A),
        .b          (B),
        .op         (ALUop),
        .result_c   (comb_result_c),
        .illegal_c  (comb_illegal_c),
        .is_shift_c (comb_shift_c)
    );

    // One-bit step of the latched shift; SRA replicates the sign bit.
    always_comb begin
        shifted_c = {work[WIDTH-1], work[WIDTH-1:1]};
        if (op == ALU_SLL) begin
            shifted_c = {work[WIDTH-2:0], 1'b0};
        end else if (op == ALU_SRL) begin
            shifted_c = {1'b0, work[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_n   = state;
        work_n    = work;
        cnt_n     = cnt;
        op_n      = op;
        result_n  = result;
        illegal_n = illegal;
        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (comb_shift_c && (A[SH_W-1:0] != '0)) begin
                        work_n  = B;
                        cnt_n   = A[SH_W-1:0];
                        op_n    = ALUop;
                        state_n = SHIFT;
                    end else begin
                        result_n  = comb_result_c;
                        illegal_n = comb_illegal_c;
                        state_n   = DONE;
                    end
                end
            end
            SHIFT: begin
                work_n = shifted_c;
                cnt_n  = cnt - SH_W'(1);
                if (cnt == SH_W'(1)) begin
                    result_n  = shifted_c;
                    illegal_n = 1'b0;
                    state_n   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Handshake flags are registered images of the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            op        <= '0;
            result    <= '0;
            illegal   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            work      <= work_n;
            cnt       <= cnt_n;
            op        <= op_n;
            result    <= result_n;
            illegal   <= illegal_n;
            in_ready  <= (state_n == IDLE);
            out_valid <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed cases, handshake scenarios and
// randomized ops against an arithmetic reference model.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        illegal;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [3:0] OP_ADDU = 4'd0,  OP_SUBU = 4'd1,  OP_SLT = 4'd2,  OP_SLTU = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR = 4'd6,  OP_NOR  = 4'd7;
    localparam logic [3:0] OP_LUI  = 4'd8,  OP_SLL  = 4'd9,  OP_SRL = 4'd10, OP_SRA  = 4'd11;
    localparam logic [3:0] OP_XXX  = 4'd15;

    alu_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUop     (ALUop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: result, illegal flag and cycles from accept to first out_valid sample.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic il, output int lat);
        int n;
        logic signed [31:0] sb;
        n   = int'(a[4:0]);
        sb  = b;
        r   = 32'h0;
        il  = 1'b0;
        lat = 1;
        case (op)
            OP_ADDU: r = a + b;
            OP_SUBU: r = a - b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_LUI:  r = {b[15:0], 16'h0000};
            OP_SLL:  begin r = b << n;   lat = n + 1; end
            OP_SRL:  begin r = b >> n;   lat = n + 1; end
            OP_SRA:  begin r = sb >>> n; lat = n + 1; end
            default: il = 1'b1;
        endcase
    endfunction

    // Runs one transaction; lat=999 when out_valid never arrives. Inputs are scrambled after accept.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic ill);
        int waited = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        in_valid = 1'b1; ALUop = op; A = a; B = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = $urandom; B = $urandom; ALUop = 4'($urandom_range(15, 0));
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = 999;
        res = result;
        ill = illegal;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUop = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", result); end
        vectors++; if (illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [3:0]  ops [11] = '{OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU, OP_LUI, OP_SRA,
                                  OP_SLL, OP_SRL, OP_XXX, OP_NOR, OP_SLL};
        logic [31:0] as  [11] = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'd4,
                                  32'd31, 32'd0, 32'h12345678, 32'h0F0F0F0F, 32'hFFFFFFE3};
        logic [31:0] bs  [11] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h0000ABCD, 32'h80000000,
                                  32'h1, 32'h80000000, 32'h9ABCDEF0, 32'h00FF00FF, 32'h1};
        logic [31:0] exp_r [11] = '{32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h0, 32'hABCD0000, 32'hF8000000,
                                    32'h80000000, 32'h80000000, 32'h0, 32'hF000F000, 32'h8};
        int          exp_l [11] = '{1, 1, 1, 1, 1, 5, 32, 1, 1, 1, 4};
        logic        exp_i [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
        int lat; logic [31:0] res; logic ill;
        for (int i = 0; i < 11; i++) begin
            do_op(ops[i], as[i], bs[i], lat, res, ill);
            vectors++; if (res !== exp_r[i]) begin miscompares++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, res, exp_r[i]); end
            vectors++; if (lat !== exp_l[i]) begin miscompares++; $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, exp_l[i]); end
            vectors++; if (ill !== exp_i[i]) begin miscompares++; $display("FAIL directed_illegal[%0d] got=%b exp=%b", i, ill, exp_i[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0]  ops [2] = '{OP_XOR, 4'd13};
        logic [31:0] exp_r [2] = '{32'h00000FF0, 32'h0};
        logic        exp_i [2] = '{1'b0, 1'b1};
        int waited;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; ALUop = ops[k]; A = 32'h0000F0F0; B = 32'h0000FF00;
            @(posedge clk); #1;
            in_valid = 1'b0;
            waited = 0;
            while (!out_valid && waited < 50) begin @(posedge clk); #1; waited++; end
            for (int c = 0; c < 3; c++) begin
                A = $urandom; B = $urandom;
                @(posedge clk); #1;
                vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", c, out_valid); end
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, in_ready); end
                vectors++; if (result !== exp_r[k]) begin miscompares++; $display("FAIL bp_result[%0d] got=%h exp=%h", c, result, exp_r[k]); end
                vectors++; if (illegal !== exp_i[k]) begin miscompares++; $display("FAIL bp_illegal[%0d] got=%b exp=%b", c, illegal, exp_i[k]); end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        int lat; logic [31:0] res; logic ill;
        in_valid = 1'b1; ALUop = OP_SLL; A = 32'd20; B = 32'h1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL midrst_result got=%h exp=0", result); end
        seen = 0;
        repeat (30) begin @(posedge clk); #1; if (out_valid) seen++; end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrst_no_late_valid got=%0d exp=0", seen); end
        do_op(OP_SUBU, 32'd10, 32'd3, lat, res, ill);
        vectors++; if (res !== 32'd7) begin miscompares++; $display("FAIL midrst_recover got=%h exp=%h", res, 32'd7); end
    endtask

    task automatic test_change_during_shift();
        int lat;
        in_valid = 1'b1; ALUop = OP_SRL; A = 32'd8; B = 32'hF0000000;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        A = 32'd1; B = 32'h0; ALUop = OP_SLL;
        lat = 3;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        in_valid = 1'b0;
        vectors++; if (lat !== 9) begin miscompares++; $display("FAIL chg_latency got=%0d exp=9", lat); end
        vectors++; if (result !== 32'h00F00000) begin miscompares++; $display("FAIL chg_result got=%h exp=00f00000", result); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int waited;
        in_valid = 1'b1; ALUop = OP_ADDU; A = 32'd100; B = 32'd23;
        @(posedge clk); #1;
        ALUop = OP_OR; A = 32'h0000FF00; B = 32'h000000FF;
        waited = 0;
        while (!out_valid && waited < 50) begin @(posedge clk); #1; waited++; end
        vectors++; if (result !== 32'd123) begin miscompares++; $display("FAIL b2b_first got=%h exp=%h", result, 32'd123); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_second_valid got=%b exp=1", out_valid); end
        vectors++; if (result !== 32'h0000FFFF) begin miscompares++; $display("FAIL b2b_second got=%h exp=0000ffff", result); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b, exp_r, res;
        logic        exp_i, ill;
        int          exp_l, lat;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(15, 0));
            a  = $urandom;
            b  = $urandom;
            model(op, a, b, exp_r, exp_i, exp_l);
            do_op(op, a, b, lat, res, ill);
            vectors++; if (res !== exp_r) begin miscompares++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp_r); end
            vectors++; if (ill !== exp_i) begin miscompares++; $display("FAIL rand_illegal[%0d] op=%0d got=%b exp=%b", i, op, ill, exp_i); end
            vectors++; if (lat !== exp_l) begin miscompares++; $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", i, op, lat, exp_l); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_shift();
        test_change_during_shift();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
